// File: rtl/fir_coeff_loader_pkg.sv
// Shared constants and loader FSM state type for the 4-tap FIR coefficient path.
package fir_coeff_loader_pkg;

  localparam int unsigned NTAPS = 4;
  localparam int unsigned CW    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StHold,
    StDone
  } ld_state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient-set load handshake: valid/ready plus the packed {c3,c2,c1,c0} word.
interface fir_coeff_loader_if
  import fir_coeff_loader_pkg::*;
#(
  parameter int unsigned W = NTAPS * CW
);

  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] coeffs;

  modport master (
    output load_valid,
    output coeffs,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  coeffs,
    output load_ready
  );

endinterface

// File: rtl/fir_coeff_loader_piso_shreg.sv
// Parallel-load, MSB-out shift register; q_msb is the register's top bit.
module fir_coeff_loader_piso_shreg
  import fir_coeff_loader_pkg::*;
#(
  parameter int unsigned W = NTAPS * CW
) (
  input  logic         ph1,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q_msb
);

  logic [W-1:0] sr_q;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d;
    end else if (shift) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign q_msb = sr_q[W-1];

endmodule

// File: rtl/fir_coeff_loader.sv
// Serialises a packed coefficient set onto the filter's shiftIn/shiftClk1 pins,
// one SETUP/HIGH/HOLD bit period per bit, MSB of c3 first.
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic                  ph1,
  input  logic                  reset,
  fir_coeff_loader_if.slave     ld,
  output logic                  shiftIn,
  output logic                  shiftClk1,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W   = NTAPS * CW;
  localparam int unsigned PhW = $clog2(HALF_PERIOD + 1);
  localparam int unsigned BcW = $clog2(W + 1);

  localparam logic [PhW-1:0] PhLast = PhW'(HALF_PERIOD - 1);
  localparam logic [BcW-1:0] BcInit = BcW'(W);
  localparam logic [BcW-1:0] BcLast = BcW'(1);

  if (HALF_PERIOD == 0) begin : g_bad_half_period
    $error("HALF_PERIOD must be at least 1");
  end

  ld_state_t      state_q, state_d;
  logic [PhW-1:0] phase_q, phase_d;
  logic [BcW-1:0] bitcnt_q, bitcnt_d;
  logic           piso_load, piso_shift;

  // The PISO top bit is itself a register, so it drives shiftIn directly.
  fir_coeff_loader_piso_shreg #(
    .W (W)
  ) u_piso (
    .ph1   (ph1),
    .reset (reset),
    .load  (piso_load),
    .shift (piso_shift),
    .d     (ld.coeffs),
    .q_msb (shiftIn)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitcnt_d   = bitcnt_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld.load_valid && ld.load_ready) begin
          state_d   = StSetup;
          phase_d   = '0;
          bitcnt_d  = BcInit;
          piso_load = 1'b1;
        end
      end
      StSetup: begin
        if (phase_q == PhLast) begin
          state_d = StHigh;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StHigh: begin
        if (phase_q == PhLast) begin
          state_d = StHold;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StHold: begin
        // Shift only after the filter's shiftClk2 has had a cycle to rise.
        piso_shift = 1'b1;
        bitcnt_d   = bitcnt_q - BcW'(1);
        phase_d    = '0;
        state_d    = (bitcnt_q == BcLast) ? StDone : StSetup;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      bitcnt_q      <= '0;
      shiftClk1     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ld.load_ready <= 1'b1;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bitcnt_q      <= bitcnt_d;
      shiftClk1     <= (state_d == StHigh);
      busy          <= (state_d inside {StSetup, StHigh, StHold});
      done          <= (state_d == StDone);
      ld.load_ready <= (state_d == StIdle);
    end
  end

endmodule
